// File: rtl/dac_parallel_delay_line.sv
// Frame-aligned programmable delay line feeding the DAC parallel port; latency is delay_active cycles (1..MAX_DELAY).
// No backpressure: hold freezes the whole pipe and discards input, and starved tap cycles are counted.
module dac_parallel_delay_line #(
    parameter int WIDTH     = 30,
    parameter int FRAME_BIT = 29,
    parameter int MAX_DELAY = 8,
    parameter int DSEL_W    = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  parallel_in,
    input  logic              in_valid,
    input  logic              hold,
    input  logic [DSEL_W-1:0] delay_sel,
    input  logic              delay_load,
    input  logic              count_clear,
    output logic [WIDTH-1:0]  parallel_out,
    output logic              out_valid,
    output logic [DSEL_W-1:0] delay_active,
    output logic              delay_pending,
    output logic [CNT_W-1:0]  underflow_count
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
    } stage_t;

    stage_t [MAX_DELAY:1] stage_q, stage_d;
    stage_t               tap;

    logic [DSEL_W-1:0] delay_active_q, delay_active_d;
    logic [DSEL_W-1:0] delay_pend_val_q, delay_pend_val_d;
    logic              delay_pending_q, delay_pending_d;
    logic [CNT_W-1:0]  underflow_count_q, underflow_count_d;
    logic              running_q, running_d;
    logic              switch_evt;

    function automatic logic [DSEL_W-1:0] clamp_sel(input logic [DSEL_W-1:0] sel);
        if (sel == '0) begin
            return DSEL_W'(1);
        end
        if (sel > DSEL_W'(MAX_DELAY)) begin
            return DSEL_W'(MAX_DELAY);
        end
        return sel;
    endfunction

    // Tap mux reads only stage flops, so outputs carry no input-to-output path.
    always_comb begin
        tap = '0;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (delay_active_q == DSEL_W'(k)) begin
                tap = stage_q[k];
            end
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            stage_d[1] = {in_valid, parallel_in};
            for (int k = 2; k <= MAX_DELAY; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    assign switch_evt = delay_pending_q & ~hold & in_valid & parallel_in[FRAME_BIT];

    // A load on the switch edge re-arms pending with the new value after the old one is applied.
    always_comb begin
        delay_active_d   = delay_active_q;
        delay_pend_val_d = delay_pend_val_q;
        delay_pending_d  = delay_pending_q;
        if (switch_evt) begin
            delay_active_d  = delay_pend_val_q;
            delay_pending_d = 1'b0;
        end
        if (delay_load) begin
            delay_pend_val_d = clamp_sel(delay_sel);
            delay_pending_d  = 1'b1;
        end
    end

    always_comb begin
        underflow_count_d = underflow_count_q;
        running_d         = running_q;
        if (count_clear) begin
            underflow_count_d = '0;
            running_d         = 1'b0;
        end else if (!hold) begin
            if (tap.vld) begin
                running_d = 1'b1;
            end else if (running_q && (underflow_count_q != '1)) begin
                underflow_count_d = underflow_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q           <= '0;
            delay_active_q    <= DSEL_W'(1);
            delay_pend_val_q  <= DSEL_W'(1);
            delay_pending_q   <= 1'b0;
            underflow_count_q <= '0;
            running_q         <= 1'b0;
        end else begin
            stage_q           <= stage_d;
            delay_active_q    <= delay_active_d;
            delay_pend_val_q  <= delay_pend_val_d;
            delay_pending_q   <= delay_pending_d;
            underflow_count_q <= underflow_count_d;
            running_q         <= running_d;
        end
    end

    assign parallel_out    = tap.vld ? tap.dat : '0;
    assign out_valid       = tap.vld;
    assign delay_active    = delay_active_q;
    assign delay_pending   = delay_pending_q;
    assign underflow_count = underflow_count_q;

endmodule

// File: tb/tb_dac_parallel_delay_line.sv
// Bench for the DAC delay line: reference model pushes per-cycle expectations, a monitor pops and compares.
module tb_dac_parallel_delay_line;

    localparam int WIDTH     = 30;
    localparam int MAX_DELAY = 8;
    localparam int DSEL_W    = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [WIDTH-1:0]  parallel_in = '0;
    logic              in_valid = 1'b0;
    logic              hold = 1'b0;
    logic [DSEL_W-1:0] delay_sel = '0;
    logic              delay_load = 1'b0;
    logic              count_clear = 1'b0;
    logic [WIDTH-1:0]  parallel_out;
    logic              out_valid;
    logic [DSEL_W-1:0] delay_active;
    logic              delay_pending;
    logic [CNT_W-1:0]  underflow_count;

    dac_parallel_delay_line #(
        .WIDTH(WIDTH), .FRAME_BIT(29), .MAX_DELAY(MAX_DELAY), .DSEL_W(DSEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .parallel_in(parallel_in), .in_valid(in_valid),
        .hold(hold), .delay_sel(delay_sel), .delay_load(delay_load), .count_clear(count_clear),
        .parallel_out(parallel_out), .out_valid(out_valid), .delay_active(delay_active),
        .delay_pending(delay_pending), .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } word_t;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        int               active;
        logic             pending;
        int               cnt;
    } exp_t;

    // Reference model: words accepted so far (newest first), latency as a plain index.
    word_t hist[$];
    int    m_active, m_pend_val, m_cnt;
    bit    m_pending, m_running;
    exp_t  exp_q[$];

    int checks = 0;
    int failures = 0;

    function automatic int clamp(input int sel);
        if (sel == 0) return 1;
        if (sel > MAX_DELAY) return MAX_DELAY;
        return sel;
    endfunction

    task automatic model_edge();
        exp_t  e;
        word_t w;
        bit    tapv, sw;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < MAX_DELAY; i++) hist.push_back('0);
            m_active = 1; m_pend_val = 1; m_pending = 0; m_cnt = 0; m_running = 0;
        end else begin
            tapv = hist[m_active-1].v;
            sw = m_pending && !hold && in_valid && parallel_in[29];
            if (count_clear) begin
                m_cnt = 0;
                m_running = 0;
            end else if (!hold) begin
                if (tapv) m_running = 1;
                else if (m_running && m_cnt < CNT_MAX) m_cnt++;
            end
            if (sw) begin
                m_active = m_pend_val;
                m_pending = 0;
            end
            if (delay_load) begin
                m_pend_val = clamp(int'(delay_sel));
                m_pending = 1;
            end
            if (!hold) begin
                w.v = in_valid;
                w.d = parallel_in;
                hist.push_front(w);
                void'(hist.pop_back());
            end
        end
        e.v = hist[m_active-1].v;
        e.d = e.v ? hist[m_active-1].d : '0;
        e.active = m_active;
        e.pending = m_pending;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst_n_i, input bit v, input logic [WIDTH-1:0] d,
                        input bit h, input bit ld, input int sel, input bit clr);
        reset_n = rst_n_i;
        in_valid = v;
        parallel_in = d;
        hold = h;
        delay_load = ld;
        delay_sel = DSEL_W'(sel);
        count_clear = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic word(input logic [WIDTH-1:0] d);
        step(1, 1, d, 0, 0, 0, 0);
    endtask

    task automatic frame(input logic [WIDTH-1:0] d);
        step(1, 1, d | 30'h2000_0000, 0, 0, 0, 0);
    endtask

    task automatic load(input int sel, input logic [WIDTH-1:0] d);
        step(1, 1, d, 0, 1, sel, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expectation is produced per edge; compare it half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", 32'(out_valid), 32'(e.v));
                check("parallel_out", 32'(parallel_out), 32'(e.d));
                check("delay_active", 32'(delay_active), 32'(e.active));
                check("delay_pending", 32'(delay_pending), 32'(e.pending));
                check("underflow_count", 32'(underflow_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] d;
        int n;
        n = 1;
        // Reset and default latency
        repeat (2) step(0, 0, '0, 0, 0, 0, 0);
        repeat (8) begin word(30'(n)); n++; end
        // Frame-aligned switch to 5
        load(5, 30'(n)); n++;
        repeat (3) begin word(30'(n)); n++; end
        frame(30'h0);
        repeat (10) begin word(30'(n)); n++; end
        // Clamp 0 -> 1, then 12 -> 8
        load(0, 30'(n)); n++;
        repeat (2) begin word(30'(n)); n++; end
        frame(30'(n)); n++;
        repeat (4) begin word(30'(n)); n++; end
        load(12, 30'(n)); n++;
        frame(30'(n)); n++;
        repeat (10) begin word(30'(n)); n++; end
        // Load 3 on the same edge as the frame that switches to 6
        load(6, 30'(n)); n++;
        step(1, 1, 30'h2000_0000 | 30'(n), 0, 1, 3, 0); n++;
        repeat (8) begin word(30'(n)); n++; end
        // Hold with a frame word presented and a delay pending
        repeat (4) step(1, 1, 30'h2000_0000 | 30'(n), 1, 0, 0, 0);
        repeat (3) begin word(30'(n)); n++; end
        frame(30'(n)); n++;
        repeat (6) begin word(30'(n)); n++; end
        // Underflow gap, saturation, then clear against a pending increment
        step(1, 1, 30'(n), 0, 0, 0, 1); n++;
        repeat (10) begin word(30'(n)); n++; end
        repeat (10) step(1, 0, 30'h1234, 0, 0, 0, 0);
        repeat (12) step(1, 0, 30'h55, 0, 0, 0, 0);
        step(1, 0, 30'h0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 30'h0, 0, 0, 0, 0);
        // Reset mid-operation with 5 active and 7 pending
        load(5, 30'(n)); n++;
        frame(30'(n)); n++;
        repeat (6) begin word(30'(n)); n++; end
        load(7, 30'(n)); n++;
        word(30'(n)); n++;
        step(0, 1, 30'h2000_0000, 0, 1, 4, 0);
        repeat (4) begin word(30'(n)); n++; end
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d = 30'($urandom());
            d[29] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 8, d,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
